sha256_msg_schedule: RTL

- Message-schedule stage of the SHA-256 core.
- Accepts one 512-bit padded block and produces W[t] for t = 0..63, one word per round advance.
- Exports the current round index; the round-constant lookup uses it to select K[t] in lockstep.
- Sits between the block input register and the compression round logic, which consumes w, round and the K value each round.

---
 rtl/sha256_msg_schedule.sv | 80 ++++++++
 1 files changed

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: a 16-word sliding window that produces W[0..63],
// one word per advance, with the round index exported for the K lookup.
module sha256_msg_schedule (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic         next,
  input  logic [511:0] block,
  output logic [31:0]  w,
  output logic [5:0]   round,
  output logic         w_valid,
  output logic         last
);

  // state  | meaning
  // IDLE   | no block loaded or block finished; next is ignored
  // ACTIVE | win[0] holds W[round]; next advances the window
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int         NUM_ROUNDS = 64;
  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

  state_t      state;
  logic [31:0] win [16];
  logic [31:0] new_word;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // W[t+16] from the window holding W[t..t+15]; all adds wrap at 32 bits
  always_comb begin
    new_word = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        win[i] <= '0;
      end
      round   <= '0;
      w_valid <= 1'b0;
      last    <= 1'b0;
      state   <= IDLE;
    end else if (init) begin
      for (int i = 0; i < 16; i++) begin
        win[i] <= block[511 - 32*i -: 32];
      end
      round   <= '0;
      w_valid <= 1'b1;
      last    <= 1'b0;
      state   <= ACTIVE;
    end else if (next && state == ACTIVE) begin
      if (round == LAST_ROUND) begin
        // end of block: window left stale, counter parked at 0 while invalid
        round   <= '0;
        w_valid <= 1'b0;
        last    <= 1'b0;
        state   <= IDLE;
      end else begin
        for (int i = 0; i < 15; i++) begin
          win[i] <= win[i+1];
        end
        win[15] <= new_word;
        round   <= round + 6'd1;
        last    <= (round == LAST_ROUND - 6'd1);
      end
    end
  end

  assign w = win[0];

endmodule
